// File: rtl/sisc_pkg.sv
// Shared definitions for the multi-cycle SISC controller:
// opcode constants, ALU operand-select encodings and FSM state encodings.
package sisc_pkg;

    localparam logic [3:0] OP_NOOP = 4'd0;
    localparam logic [3:0] OP_LOD  = 4'd1;
    localparam logic [3:0] OP_STR  = 4'd2;
    localparam logic [3:0] OP_SWP  = 4'd3;
    localparam logic [3:0] OP_BRA  = 4'd4;
    localparam logic [3:0] OP_BRR  = 4'd5;
    localparam logic [3:0] OP_BNE  = 4'd6;
    localparam logic [3:0] OP_BNR  = 4'd7;
    localparam logic [3:0] OP_ALU  = 4'd8;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [1:0] ALU_RR   = 2'b00;
    localparam logic [1:0] ALU_IMM  = 2'b01;
    localparam logic [1:0] ALU_PASS = 2'b10;

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_MEM    = 4'd4,
        S_WB     = 4'd5,
        S_HALT   = 4'd6,
        S_ERR    = 4'd7
    } state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait-cycle counter.
// Ports: clk, rst_f (sync, active-high), clr (restart count), inc (one more
// wait cycle), expired (the current wait cycle is the TMO-th one).
module mem_wait_timer #(
    parameter int TMO = 15
) (
    input  logic clk,
    input  logic rst_f,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int W = $clog2(TMO + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst_f || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != W'(TMO))) begin
            cnt <= cnt + 1'b1;
        end
    end

    // cnt counts completed wait cycles, so the TMO-th wait cycle is the
    // one where cnt == TMO-1; the controller only gives up if that cycle
    // also ends without an ack.
    assign expired = (cnt == W'(TMO - 1));

endmodule

// File: rtl/mcycle_ctrl.sv
// Multi-cycle SISC control unit: FETCH/DECODE/EXEC/MEM/WB sequencing,
// branch resolution, memory wait timeout and terminal HALT/ERR states.
// Ports: clk, rst_f, opcode, mm, stat, mem_ack in; datapath controls,
// memory strobes, halted/err status and state_o out.
module mcycle_ctrl
    import sisc_pkg::*;
#(
    parameter int OPW    = 4,
    parameter int MMW    = 4,
    parameter int AM_IMM = 8,
    parameter int TMO    = 15
) (
    input  logic           clk,
    input  logic           rst_f,
    input  logic [OPW-1:0] opcode,
    input  logic [MMW-1:0] mm,
    input  logic [MMW-1:0] stat,
    input  logic           mem_ack,
    output logic           rf_we,
    output logic           ir_load,
    output logic           pc_write,
    output logic           pc_rst,
    output logic           pc_sel,
    output logic           br_sel,
    output logic           rb_sel,
    output logic           wb_sel,
    output logic [1:0]     alu_op,
    output logic           mem_req,
    output logic           mem_we,
    output logic           halted,
    output logic           err,
    output logic [3:0]     state_o
);

    state_t state, state_n;
    logic   expired;
    logic   is_lod, is_str, is_swp, is_alu, is_hlt;
    logic   is_bra, is_brr, is_bne, is_bnr;
    logic   mask_clr;
    logic [1:0] alu_sel;

    assign is_lod = (opcode == OPW'(OP_LOD));
    assign is_str = (opcode == OPW'(OP_STR));
    assign is_swp = (opcode == OPW'(OP_SWP));
    assign is_bra = (opcode == OPW'(OP_BRA));
    assign is_brr = (opcode == OPW'(OP_BRR));
    assign is_bne = (opcode == OPW'(OP_BNE));
    assign is_bnr = (opcode == OPW'(OP_BNR));
    assign is_alu = (opcode == OPW'(OP_ALU));
    assign is_hlt = (opcode == {OPW{1'b1}});

    assign mask_clr = ((stat & mm) == '0);
    assign alu_sel  = (mm == MMW'(AM_IMM)) ? ALU_IMM : ALU_RR;

    always_ff @(posedge clk) begin
        if (rst_f) begin
            state <= S_RST;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        rf_we    = 1'b0;
        ir_load  = 1'b0;
        pc_write = 1'b0;
        pc_rst   = 1'b0;
        pc_sel   = 1'b0;
        br_sel   = 1'b0;
        rb_sel   = 1'b0;
        wb_sel   = 1'b0;
        alu_op   = ALU_PASS;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        halted   = 1'b0;
        err      = 1'b0;
        if (rst_f) begin
            // Reset dominates whatever state we were in.
            pc_rst = 1'b1;
        end else begin
            unique case (state)
                S_RST: begin
                    pc_rst  = 1'b1;
                    state_n = S_FETCH;
                end
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        ir_load  = 1'b1;
                        pc_write = 1'b1;
                        state_n  = S_DECODE;
                    end else if (expired) begin
                        state_n = S_ERR;
                    end
                end
                S_DECODE: begin
                    br_sel = is_bra | is_bne;
                    if (is_bra || is_brr ||
                        ((is_bne || is_bnr) && mask_clr)) begin
                        pc_write = 1'b1;
                        pc_sel   = 1'b1;
                    end
                    state_n = is_hlt ? S_HALT : S_EXEC;
                end
                S_EXEC: begin
                    if (is_alu) begin
                        alu_op = alu_sel;
                    end else if (is_lod || is_str) begin
                        alu_op = ALU_IMM;
                    end
                    if (is_lod || is_str) begin
                        state_n = S_MEM;
                    end else if (is_alu || is_swp) begin
                        state_n = S_WB;
                    end else begin
                        state_n = S_FETCH;
                    end
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = is_str;
                    alu_op  = ALU_IMM;
                    if (mem_ack) begin
                        state_n = is_lod ? S_WB : S_FETCH;
                    end else if (expired) begin
                        state_n = S_ERR;
                    end
                end
                S_WB: begin
                    rf_we  = is_alu | is_lod | is_swp;
                    wb_sel = is_lod;
                    rb_sel = is_swp;
                    if (is_alu) begin
                        alu_op = alu_sel;
                    end
                    state_n = S_FETCH;
                end
                S_HALT: begin
                    halted = 1'b1;
                end
                S_ERR: begin
                    err = 1'b1;
                end
                default: begin
                    state_n = S_RST;
                end
            endcase
        end
    end

    mem_wait_timer #(
        .TMO(TMO)
    ) u_timer (
        .clk    (clk),
        .rst_f  (rst_f),
        .clr    (state_n != state),
        .inc    (((state == S_FETCH) || (state == S_MEM)) && !mem_ack),
        .expired(expired)
    );

    assign state_o = state;

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Self-checking bench for mcycle_ctrl (TMO=4): per-cycle stimulus with
// expected state/outputs queued on drive and compared at the falling edge.
module tb_mcycle_ctrl;
    import sisc_pkg::*;

    logic       clk = 1'b0;
    logic       rst_f = 1'b1;
    logic [3:0] opcode = '0;
    logic [3:0] mm = '0;
    logic [3:0] stat = '0;
    logic       mem_ack = 1'b0;
    logic       rf_we, ir_load, pc_write, pc_rst, pc_sel, br_sel;
    logic       rb_sel, wb_sel, mem_req, mem_we, halted, err;
    logic [1:0] alu_op;
    logic [3:0] state_o;

    int n_run = 0;
    int n_fail = 0;

    localparam logic [13:0] RFWE  = 14'h2000;
    localparam logic [13:0] IRLD  = 14'h1000;
    localparam logic [13:0] PCW   = 14'h0800;
    localparam logic [13:0] PCRST = 14'h0400;
    localparam logic [13:0] PCSEL = 14'h0200;
    localparam logic [13:0] BRSEL = 14'h0100;
    localparam logic [13:0] RBSEL = 14'h0080;
    localparam logic [13:0] WBSEL = 14'h0040;
    localparam logic [13:0] PASS  = 14'h0020;
    localparam logic [13:0] A_IMM = 14'h0010;
    localparam logic [13:0] A_RR  = 14'h0000;
    localparam logic [13:0] REQ   = 14'h0008;
    localparam logic [13:0] MWE   = 14'h0004;
    localparam logic [13:0] HLTD  = 14'h0002;
    localparam logic [13:0] ERRB  = 14'h0001;
    localparam logic [13:0] FACK  = REQ | IRLD | PCW | PASS;
    localparam logic [13:0] RSTO  = PCRST | PASS;

    typedef struct packed {
        logic       rst;
        logic [3:0] op;
        logic [3:0] mm;
        logic [3:0] st;
        logic       ack;
        logic [3:0] s;
        logic [13:0] o;
    } stim_t;

    stim_t sb[$];

    mcycle_ctrl #(
        .OPW(4), .MMW(4), .AM_IMM(8), .TMO(4)
    ) dut (
        .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm),
        .stat(stat), .mem_ack(mem_ack), .rf_we(rf_we),
        .ir_load(ir_load), .pc_write(pc_write), .pc_rst(pc_rst),
        .pc_sel(pc_sel), .br_sel(br_sel), .rb_sel(rb_sel),
        .wb_sel(wb_sel), .alu_op(alu_op), .mem_req(mem_req),
        .mem_we(mem_we), .halted(halted), .err(err),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [17:0] obs();
        return {state_o, rf_we, ir_load, pc_write, pc_rst, pc_sel,
                br_sel, rb_sel, wb_sel, alu_op, mem_req, mem_we,
                halted, err};
    endfunction

    function automatic stim_t mk(logic r, logic [3:0] op,
                                 logic [3:0] m, logic [3:0] st,
                                 logic ack, state_t s,
                                 logic [13:0] o);
        stim_t x;
        x.rst = r; x.op = op; x.mm = m; x.st = st;
        x.ack = ack; x.s = s; x.o = o;
        return x;
    endfunction

    // Drive one cycle's inputs, queue its expectation, wait to sample.
    task automatic apply(input stim_t s);
        @(posedge clk);
        #1;
        rst_f = s.rst; opcode = s.op; mm = s.mm;
        stat = s.st; mem_ack = s.ack;
        sb.push_back(s);
        @(negedge clk);
    endtask

    task automatic test_reset();
        stim_t v[$];
        stim_t e;
        v.push_back(mk(1, 0, 0, 0, 0, S_RST, RSTO));
        v.push_back(mk(1, 0, 0, 0, 1, S_RST, RSTO));
        v.push_back(mk(0, 0, 0, 0, 1, S_RST, RSTO));
        foreach (v[i]) begin
            apply(v[i]); e = sb.pop_front(); n_run++;
            if (obs() !== {e.s, e.o}) begin
                n_fail++;
                $display("FAIL reset[%0d] got %h/%b want %h/%b",
                         i, state_o, obs() & 18'h3fff, e.s, e.o);
            end
        end
    endtask

    task automatic test_alu();
        stim_t v[$];
        stim_t e;
        v.push_back(mk(0, 8, 0, 0, 1, S_FETCH, FACK));
        v.push_back(mk(0, 8, 0, 0, 0, S_DECODE, PASS));
        v.push_back(mk(0, 8, 0, 0, 0, S_EXEC, A_RR));
        v.push_back(mk(0, 8, 0, 0, 0, S_WB, RFWE | A_RR));
        v.push_back(mk(0, 8, 8, 0, 1, S_FETCH, FACK));
        v.push_back(mk(0, 8, 8, 0, 0, S_DECODE, PASS));
        v.push_back(mk(0, 8, 8, 0, 0, S_EXEC, A_IMM));
        v.push_back(mk(0, 8, 8, 0, 0, S_WB, RFWE | A_IMM));
        foreach (v[i]) begin
            apply(v[i]); e = sb.pop_front(); n_run++;
            if (obs() !== {e.s, e.o}) begin
                n_fail++;
                $display("FAIL alu[%0d] got %h/%b want %h/%b",
                         i, state_o, obs() & 18'h3fff, e.s, e.o);
            end
        end
    endtask

    task automatic test_lod_str();
        stim_t v[$];
        stim_t e;
        v.push_back(mk(0, 1, 0, 0, 0, S_FETCH, REQ | PASS));
        v.push_back(mk(0, 1, 0, 0, 0, S_FETCH, REQ | PASS));
        v.push_back(mk(0, 1, 0, 0, 0, S_FETCH, REQ | PASS));
        v.push_back(mk(0, 1, 0, 0, 1, S_FETCH, FACK));
        v.push_back(mk(0, 1, 0, 0, 1, S_DECODE, PASS));
        v.push_back(mk(0, 1, 0, 0, 0, S_EXEC, A_IMM));
        v.push_back(mk(0, 1, 0, 0, 0, S_MEM, REQ | A_IMM));
        v.push_back(mk(0, 1, 0, 0, 0, S_MEM, REQ | A_IMM));
        v.push_back(mk(0, 1, 0, 0, 1, S_MEM, REQ | A_IMM));
        v.push_back(mk(0, 1, 0, 0, 0, S_WB, RFWE | WBSEL | PASS));
        v.push_back(mk(0, 2, 0, 0, 1, S_FETCH, FACK));
        v.push_back(mk(0, 2, 0, 0, 0, S_DECODE, PASS));
        v.push_back(mk(0, 2, 0, 0, 0, S_EXEC, A_IMM));
        v.push_back(mk(0, 2, 0, 0, 0, S_MEM, REQ | MWE | A_IMM));
        v.push_back(mk(0, 2, 0, 0, 1, S_MEM, REQ | MWE | A_IMM));
        foreach (v[i]) begin
            apply(v[i]); e = sb.pop_front(); n_run++;
            if (obs() !== {e.s, e.o}) begin
                n_fail++;
                $display("FAIL lod_str[%0d] got %h/%b want %h/%b",
                         i, state_o, obs() & 18'h3fff, e.s, e.o);
            end
        end
    endtask

    task automatic test_branch();
        stim_t v[$];
        stim_t e;
        v.push_back(mk(0, 6, 4, 2, 1, S_FETCH, FACK));
        v.push_back(mk(0, 6, 4, 2, 0, S_DECODE,
                       PCW | PCSEL | BRSEL | PASS));
        v.push_back(mk(0, 6, 4, 2, 0, S_EXEC, PASS));
        v.push_back(mk(0, 6, 2, 2, 1, S_FETCH, FACK));
        v.push_back(mk(0, 6, 2, 2, 0, S_DECODE, BRSEL | PASS));
        v.push_back(mk(0, 6, 2, 2, 0, S_EXEC, PASS));
        v.push_back(mk(0, 5, 2, 2, 1, S_FETCH, FACK));
        v.push_back(mk(0, 5, 2, 2, 0, S_DECODE, PCW | PCSEL | PASS));
        v.push_back(mk(0, 5, 2, 2, 0, S_EXEC, PASS));
        v.push_back(mk(0, 7, 3, 1, 1, S_FETCH, FACK));
        v.push_back(mk(0, 7, 3, 1, 0, S_DECODE, PASS));
        v.push_back(mk(0, 7, 3, 1, 0, S_EXEC, PASS));
        v.push_back(mk(0, 4, 3, 1, 1, S_FETCH, FACK));
        v.push_back(mk(0, 4, 3, 1, 0, S_DECODE,
                       PCW | PCSEL | BRSEL | PASS));
        v.push_back(mk(0, 4, 3, 1, 0, S_EXEC, PASS));
        foreach (v[i]) begin
            apply(v[i]); e = sb.pop_front(); n_run++;
            if (obs() !== {e.s, e.o}) begin
                n_fail++;
                $display("FAIL branch[%0d] got %h/%b want %h/%b",
                         i, state_o, obs() & 18'h3fff, e.s, e.o);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t v[$];
        stim_t e;
        v.push_back(mk(0, 3, 0, 0, 1, S_FETCH, FACK));
        v.push_back(mk(0, 3, 0, 0, 0, S_DECODE, PASS));
        v.push_back(mk(0, 3, 0, 0, 0, S_EXEC, PASS));
        v.push_back(mk(0, 3, 0, 0, 0, S_WB, RFWE | RBSEL | PASS));
        v.push_back(mk(0, 12, 0, 0, 1, S_FETCH, FACK));
        v.push_back(mk(0, 12, 0, 0, 1, S_DECODE, PASS));
        v.push_back(mk(0, 12, 0, 0, 1, S_EXEC, PASS));
        v.push_back(mk(0, 0, 0, 0, 1, S_FETCH, FACK));
        v.push_back(mk(0, 0, 0, 0, 0, S_DECODE, PASS));
        v.push_back(mk(0, 0, 0, 0, 0, S_EXEC, PASS));
        foreach (v[i]) begin
            apply(v[i]); e = sb.pop_front(); n_run++;
            if (obs() !== {e.s, e.o}) begin
                n_fail++;
                $display("FAIL b2b[%0d] got %h/%b want %h/%b",
                         i, state_o, obs() & 18'h3fff, e.s, e.o);
            end
        end
    endtask

    task automatic test_timeout();
        stim_t v[$];
        stim_t e;
        // Ack on the 4th MEM wait cycle still completes.
        v.push_back(mk(0, 1, 0, 0, 1, S_FETCH, FACK));
        v.push_back(mk(0, 1, 0, 0, 0, S_DECODE, PASS));
        v.push_back(mk(0, 1, 0, 0, 0, S_EXEC, A_IMM));
        v.push_back(mk(0, 1, 0, 0, 0, S_MEM, REQ | A_IMM));
        v.push_back(mk(0, 1, 0, 0, 0, S_MEM, REQ | A_IMM));
        v.push_back(mk(0, 1, 0, 0, 0, S_MEM, REQ | A_IMM));
        v.push_back(mk(0, 1, 0, 0, 1, S_MEM, REQ | A_IMM));
        v.push_back(mk(0, 1, 0, 0, 0, S_WB, RFWE | WBSEL | PASS));
        // No ack: four MEM wait cycles then ERR.
        v.push_back(mk(0, 2, 0, 0, 1, S_FETCH, FACK));
        v.push_back(mk(0, 2, 0, 0, 0, S_DECODE, PASS));
        v.push_back(mk(0, 2, 0, 0, 0, S_EXEC, A_IMM));
        v.push_back(mk(0, 2, 0, 0, 0, S_MEM, REQ | MWE | A_IMM));
        v.push_back(mk(0, 2, 0, 0, 0, S_MEM, REQ | MWE | A_IMM));
        v.push_back(mk(0, 2, 0, 0, 0, S_MEM, REQ | MWE | A_IMM));
        v.push_back(mk(0, 2, 0, 0, 0, S_MEM, REQ | MWE | A_IMM));
        v.push_back(mk(0, 2, 0, 0, 0, S_ERR, ERRB | PASS));
        v.push_back(mk(0, 2, 0, 0, 1, S_ERR, ERRB | PASS));
        v.push_back(mk(1, 2, 0, 0, 0, S_ERR, RSTO));
        v.push_back(mk(0, 2, 0, 0, 0, S_RST, RSTO));
        // FETCH times out the same way.
        v.push_back(mk(0, 0, 0, 0, 0, S_FETCH, REQ | PASS));
        v.push_back(mk(0, 0, 0, 0, 0, S_FETCH, REQ | PASS));
        v.push_back(mk(0, 0, 0, 0, 0, S_FETCH, REQ | PASS));
        v.push_back(mk(0, 0, 0, 0, 0, S_FETCH, REQ | PASS));
        v.push_back(mk(0, 0, 0, 0, 1, S_ERR, ERRB | PASS));
        v.push_back(mk(1, 0, 0, 0, 0, S_ERR, RSTO));
        v.push_back(mk(0, 0, 0, 0, 0, S_RST, RSTO));
        foreach (v[i]) begin
            apply(v[i]); e = sb.pop_front(); n_run++;
            if (obs() !== {e.s, e.o}) begin
                n_fail++;
                $display("FAIL timeout[%0d] got %h/%b want %h/%b",
                         i, state_o, obs() & 18'h3fff, e.s, e.o);
            end
        end
    endtask

    task automatic test_halt();
        stim_t v[$];
        stim_t e;
        v.push_back(mk(0, 15, 0, 0, 1, S_FETCH, FACK));
        v.push_back(mk(0, 15, 0, 0, 0, S_DECODE, PASS));
        v.push_back(mk(0, 15, 0, 0, 0, S_HALT, HLTD | PASS));
        v.push_back(mk(0, 15, 0, 0, 1, S_HALT, HLTD | PASS));
        v.push_back(mk(0, 1, 0, 0, 1, S_HALT, HLTD | PASS));
        v.push_back(mk(1, 1, 0, 0, 0, S_HALT, RSTO));
        v.push_back(mk(0, 1, 0, 0, 0, S_RST, RSTO));
        foreach (v[i]) begin
            apply(v[i]); e = sb.pop_front(); n_run++;
            if (obs() !== {e.s, e.o}) begin
                n_fail++;
                $display("FAIL halt[%0d] got %h/%b want %h/%b",
                         i, state_o, obs() & 18'h3fff, e.s, e.o);
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        stim_t v[$];
        stim_t e;
        v.push_back(mk(0, 1, 0, 0, 1, S_FETCH, FACK));
        v.push_back(mk(0, 1, 0, 0, 0, S_DECODE, PASS));
        v.push_back(mk(0, 1, 0, 0, 0, S_EXEC, A_IMM));
        v.push_back(mk(0, 1, 0, 0, 0, S_MEM, REQ | A_IMM));
        v.push_back(mk(0, 1, 0, 0, 0, S_MEM, REQ | A_IMM));
        v.push_back(mk(1, 1, 0, 0, 0, S_MEM, RSTO));
        v.push_back(mk(0, 0, 0, 0, 0, S_RST, RSTO));
        // A stale count would trip ERR before the 4th cycle's ack.
        v.push_back(mk(0, 0, 0, 0, 0, S_FETCH, REQ | PASS));
        v.push_back(mk(0, 0, 0, 0, 0, S_FETCH, REQ | PASS));
        v.push_back(mk(0, 0, 0, 0, 0, S_FETCH, REQ | PASS));
        v.push_back(mk(0, 0, 0, 0, 1, S_FETCH, FACK));
        v.push_back(mk(0, 0, 0, 0, 0, S_DECODE, PASS));
        v.push_back(mk(0, 0, 0, 0, 0, S_EXEC, PASS));
        v.push_back(mk(0, 0, 0, 0, 0, S_FETCH, REQ | PASS));
        foreach (v[i]) begin
            apply(v[i]); e = sb.pop_front(); n_run++;
            if (obs() !== {e.s, e.o}) begin
                n_fail++;
                $display("FAIL rst_mem[%0d] got %h/%b want %h/%b",
                         i, state_o, obs() & 18'h3fff, e.s, e.o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_lod_str();
        test_branch();
        test_back_to_back();
        test_timeout();
        test_halt();
        test_reset_mid_mem();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/mcycle_ctrl.md
MCYCLE_CTRL -- requirements
Module: mcycle_ctrl

Interface
REQ-001 SHALL have parameter OPW, default 4: opcode width.
REQ-002 SHALL have parameter MMW, default 4: mode/mask field width; stat has the same width.
REQ-003 SHALL have parameter AM_IMM, default 8: mm value selecting the immediate ALU operand.
REQ-004 SHALL have parameter TMO, default 15: maximum memory wait cycles before error; legal range 1..255.
REQ-005 SHALL have the following ports:
- clk  in  1  sole clock, rising edge.
- rst_f  in  1  synchronous, active-high reset.
- opcode  in  OPW  instruction opcode field.
- mm  in  MMW  mode/mask field.
- stat  in  MMW  status flags.
- mem_ack  in  1  memory transfer complete.
- rf_we, ir_load, pc_write, pc_rst, pc_sel, br_sel, rb_sel  out  1  datapath controls.
- wb_sel  out  1  0 = ALU result, 1 = memory data.
- alu_op  out  2  00 = reg-reg, 01 = immediate, 10 = pass/no-op.
- mem_req, mem_we  out  1  memory request and write strobe.
- halted, err  out  1  sticky status.
- state_o  out  4  current state encoding.

Function
REQ-006 States SHALL be RST, FETCH, DECODE, EXEC, MEM, WB, HALT and ERR, all driven from one registered state register.
REQ-007 All outputs SHALL be combinational from state, opcode, mm, stat and mem_ack; defaults are 0, except alu_op, which defaults to 10.
REQ-008 RST: pc_rst=1; next state FETCH.
REQ-009 FETCH: mem_req=1.
- mem_ack=1: ir_load=1, pc_write=1, pc_sel=0 in that same cycle; next state DECODE.
- mem_ack=0: stay in FETCH.
REQ-010 DECODE, opcode HLT (all ones): next state HALT; otherwise next state EXEC.
REQ-011 DECODE, branch select: br_sel=1 for BRA(4) and BNE(6); br_sel=0 for BRR(5) and BNR(7).
REQ-012 DECODE, branch taken: pc_write=1 and pc_sel=1 for BRA/BRR unconditionally, and for BNE/BNR only when (stat & mm)==0.
REQ-013 EXEC, opcode ALU(8): alu_op=01 if mm==AM_IMM, else 00.
REQ-014 EXEC, opcode LOD(1)/STR(2): alu_op=01 (address calculation).
REQ-015 EXEC next state: MEM for LOD/STR; WB for ALU/SWP(3); FETCH for all others.
REQ-016 MEM: mem_req=1, alu_op=01, and mem_we=1 for STR.
REQ-017 MEM exit: on mem_ack, LOD goes to WB and STR goes to FETCH; without mem_ack, stay in MEM.
REQ-018 WB:
- ALU: rf_we=1, wb_sel=0, alu_op held as in EXEC.
- LOD: rf_we=1, wb_sel=1.
- SWP: rf_we=1, rb_sel=1.
- Next state: FETCH.
REQ-019 A wait counter SHALL clear on every state change and increment each cycle spent in FETCH or MEM without mem_ack.
REQ-020 When the wait counter reaches TMO with mem_ack still 0, next state SHALL be ERR.
REQ-021 mem_ack arriving in the same cycle the counter reaches TMO SHALL complete the transfer normally; the ack wins.
REQ-022 mem_ack SHALL be ignored outside FETCH and MEM.
REQ-023 HALT and ERR SHALL be terminal: mem_req=0, all write enables 0, exit only via rst_f.
REQ-024 halted=1 in HALT; err=1 in ERR.
REQ-025 Unlisted opcodes SHALL execute as NOOP: DECODE → EXEC → FETCH with no writes.

Reset
REQ-026 rst_f=1 at a rising clk edge SHALL force state RST and clear the wait counter, from any state, including mid-transfer and in HALT/ERR.
REQ-027 While rst_f=1: pc_rst=1, mem_req=0, all other outputs at their REQ-007 defaults.
REQ-028 The first rising edge with rst_f=0 SHALL move RST → FETCH.

Structure
REQ-029 Package sisc_pkg SHALL hold the opcode constants (NOOP, LOD, STR, SWP, BRA, BRR, BNE, BNR, ALU, HLT), the alu_op encodings and the state encodings.
REQ-030 The wait counter SHALL be a sub-module, mem_wait_timer (parameter TMO; inputs clk, rst_f, clr, inc; output expired), of width $clog2(TMO+1).

Verification
REQ-031 Reset then ALU reg-reg (opcode 8, mm 0) with ack on the first FETCH cycle: states FETCH, DECODE, EXEC, WB; alu_op=00 in EXEC; rf_we=1 and wb_sel=0 only in WB.
REQ-032 LOD with ack delayed 3 cycles in FETCH and 2 in MEM: mem_req held until ack; WB rf_we=1, wb_sel=1; total 10 cycles from the first FETCH to the next FETCH.
REQ-033 BNE with stat=0010, mm=0100: pc_write=1, pc_sel=1, br_sel=1 in DECODE. Same with mm=0010: pc_write=0.
REQ-034 TMO=4, no ack in MEM: ERR entered after 4 wait cycles, err=1. Ack on the 4th cycle: normal completion, err=0.
REQ-035 HLT: halted=1 and no further mem_req. rst_f pulsed mid-MEM: next state RST, mem_req=0, pc_rst=1.
